mips_memory_responder: RTL
==========================

// Module: mips_memory_responder
// PURPOSE
//  Memory-side responder for the single-cycle MIPS processor's memory interface. Serves instruction fetches
//  and lw/sw data accesses from one word-addressed array with programmable wait states.
//  Returns a valid/ready handshake so the processor (or a stall wrapper) knows when results are usable.
//  Sits between the processor core and the bench program image.
// PARAMETERS
//  DEPTH_WORDS  1024      number of 32-bit words in the array
//  BASE_ADDR    32'h3000  byte address of word 0 (processor reset PC)
//  WAIT_CYCLES  2         extra cycles between request capture and response (0 allowed)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  inst_req     in   1   instruction fetch request
//  inst_addr    in   32  fetch byte address
//  inst_rdata   out  32  fetched instruction
//  inst_valid   out  1   one-cycle pulse: inst_rdata valid
//  mem_read     in   1   data read request (lw)
//  mem_write    in   1   data write request (sw)
//  data_addr    in   32  data byte address
//  data_wdata   in   32  store data
//  data_rdata   out  32  load data
//  data_ready   out  1   one-cycle pulse: data access complete
//  fault        out  1   one-cycle pulse with valid/ready: request rejected
//  load_en      in   1   bench preload write (bypasses FSM, only honoured in IDLE)
//  load_addr    in   32  preload byte address
//  load_data    in   32  preload word
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0. inst_rdata, data_rdata = 0. inst_valid, data_ready, fault = 0.
//    Array contents are not cleared.
//  - Index = (addr - BASE_ADDR) >> 2. An address is bad if addr[1:0] != 0, addr < BASE_ADDR, or
//    index >= DEPTH_WORDS.
//  - FSM IDLE -> WAIT -> RESP -> IDLE:
//    - Requests are sampled only in IDLE. Captured address, data and kind are registered.
//    - Requester holds inputs stable until its response pulse.
//    - WAIT counts WAIT_CYCLES. If WAIT_CYCLES = 0, WAIT is skipped.
//  - Response latency: the pulse is asserted exactly WAIT_CYCLES+1 cycles after the capture edge.
//    Outputs are registered.
//  - Arbitration: when a data request and inst_req are both present in IDLE, data is served first.
//    inst_req is served on the next IDLE cycle.
//  - Reads: rdata = array[index] at the RESP cycle. rdata holds its value until the next response of that kind.
//  - Writes: array[index] <= data_wdata on the RESP edge. data_ready pulses, data_rdata is unchanged.
//    A read issued after the write returns the new value.
//  - Fault (bad address, or mem_read & mem_write both high):
//    - The normal latency still applies.
//    - The matching valid/ready pulses together with fault.
//    - rdata = 0 and no array write occurs.
//  - inst_valid and data_ready are never high in the same cycle.
//  - load_en in IDLE writes array[load index] immediately and takes priority over request capture.
//    A bad load address is ignored silently.
//  - Reset asserted mid-WAIT/RESP: transaction aborted, no write commit, no pulse after release.
//  - Counter width $clog2(WAIT_CYCLES+1), minimum 1 bit. It saturates and never wraps.
// STRUCTURE
//  - Shared package mem_pkg:
//    - state encoding localparams S_IDLE/S_WAIT/S_RESP
//    - request-kind codes K_INST/K_LOAD/K_STORE
//    - HALT_INSTR = 32'hFC00_0000
//    - BASE_ADDR default
//  - One sub-module: mem_word_array (DEPTH_WORDS x 32). One synchronous write port, one combinational read port.
//    The FSM, arbitration and address check stay in the top module.
// TESTING
//  1. Reset with rst_n=0, then release; preload 0x3000=0x20080005 and fetch 0x3000 with WAIT_CYCLES=2.
//     -> inst_valid pulses 3 cycles after capture, inst_rdata=0x20080005, fault=0.
//  2. sw: data_addr=0x3010, data_wdata=0xDEADBEEF; then lw from 0x3010.
//     -> data_ready pulses for both accesses; the lw returns data_rdata=0xDEADBEEF.
//  3. inst_req(0x3004) and mem_read(0x3010) raised in the same cycle.
//     -> data_ready first; inst_valid exactly WAIT_CYCLES+2 cycles later; never coincident.
//  4. Bad addresses: lw 0x3002, then sw 0x2FFC, then read at BASE+4*DEPTH_WORDS.
//     -> each response has fault=1 and rdata=0; a readback confirms no array word changed.
//  5. Pull rst_n low during WAIT of sw 0x3020=0x1234.
//     -> outputs return to 0 at once, no pulse after release, and a later lw 0x3020 returns the preloaded value.
//  6. Repeat tests 1-2 with WAIT_CYCLES=0.
//     -> response pulse on the cycle after capture; back-to-back fetches of 0x3000/0x3004 get one response every 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS memory responder: FSM states, request kinds,
// address defaults and the address legality check used by capture and preload paths.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_INST  = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_e;

  localparam logic [31:0] HALT_INSTR        = 32'hFC00_0000;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_3000;

  // A byte address is unusable if misaligned, below the array base, or past its last word.
  function automatic logic addr_is_bad(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned depth);
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) || (addr < base) || (idx >= depth);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage for the responder: one synchronous write port, one combinational read port.
// Contents are intentionally not reset so a preloaded program image survives a core reset.
module mem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Single write port shared by preload and committed stores.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_memory_responder.sv
// Memory-side responder: serves instruction fetches and lw/sw from one word array.
// Fixed latency: response pulse WAIT_CYCLES+1 cycles after the capture edge, outputs registered.
// Requests are only sampled in IDLE; data wins over fetch; bench preload wins over both.
module mips_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        fault,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_e        state_q;
  kind_e         kind_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          bad_q;
  logic [31:0]   inst_rdata_q;
  logic [31:0]   data_rdata_q;
  logic          inst_valid_q;
  logic          data_ready_q;
  logic          fault_pulse_q;

  logic          data_req;
  logic [31:0]   req_addr;
  logic          req_bad;
  logic [AW-1:0] req_idx;
  logic          load_bad;
  logic [AW-1:0] load_idx;

  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  assign data_req = mem_read | mem_write;
  assign req_addr = data_req ? data_addr : inst_addr;
  // Simultaneous read and write is an illegal request, faulted like a bad address.
  assign req_bad  = addr_is_bad(req_addr, BASE_ADDR, DEPTH_WORDS) | (mem_read & mem_write);
  assign req_idx  = AW'((req_addr - BASE_ADDR) >> 2);
  assign load_bad = addr_is_bad(load_addr, BASE_ADDR, DEPTH_WORDS);
  assign load_idx = AW'((load_addr - BASE_ADDR) >> 2);

  // Write port arbitration: preloads only in IDLE, stores only commit on the RESP edge.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = idx_q;
    arr_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      if (load_en && !load_bad) begin
        arr_we    = 1'b1;
        arr_waddr = load_idx;
        arr_wdata = load_data;
      end
    end else if (state_q == S_RESP && kind_q == K_STORE && !bad_q) begin
      arr_we = 1'b1;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS(int'(DEPTH_WORDS)),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .raddr_i(idx_q),
    .rdata_o(arr_rdata)
  );

  // Request FSM with registered response pulses; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      kind_q        <= K_INST;
      cnt_q         <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      bad_q         <= 1'b0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
      inst_valid_q  <= 1'b0;
      data_ready_q  <= 1'b0;
      fault_pulse_q <= 1'b0;
    end else begin
      inst_valid_q  <= 1'b0;
      data_ready_q  <= 1'b0;
      fault_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!load_en && (data_req || inst_req)) begin
            if (data_req) begin
              kind_q <= mem_write && !mem_read ? K_STORE : K_LOAD;
            end else begin
              kind_q <= K_INST;
            end
            idx_q   <= req_idx;
            wdata_q <= data_wdata;
            bad_q   <= req_bad;
            cnt_q   <= '0;
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter stops at its last value; it never wraps.
          if (cnt_q == CNT_LAST) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q       <= S_IDLE;
          fault_pulse_q <= bad_q;
          if (kind_q == K_INST) begin
            inst_valid_q <= 1'b1;
            inst_rdata_q <= bad_q ? 32'h0 : arr_rdata;
          end else begin
            data_ready_q <= 1'b1;
            if (bad_q) begin
              data_rdata_q <= 32'h0;
            end else if (kind_q == K_LOAD) begin
              data_rdata_q <= arr_rdata;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign inst_valid = inst_valid_q;
  assign data_rdata = data_rdata_q;
  assign data_ready = data_ready_q;
  assign fault      = fault_pulse_q;

endmodule
